// File: rtl/clk_div_pkg.sv
// Shared types and defaults for the divided-clock monitor (clk_div_monitor).
package clk_div_pkg;

  localparam int DEF_CNT_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_MEAS = 2'd2
  } div_mon_state_t;

endpackage

// File: rtl/edge_det.sv
// Samples a single-bit clock-like input into the clk domain and reports rise/fall.
// Defining DIV_MON_SYNC_EN inserts a two-flop synchroniser ahead of the sampling flop.
module edge_det (
  input  logic clk,
  input  logic rstn,
  input  logic i_d,
  output logic o_s,
  output logic o_rise,
  output logic o_fall
);

  logic w_samp;
  logic r_s;
  logic r_d;

`ifdef DIV_MON_SYNC_EN
  logic [1:0] r_sync;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_sync <= 2'b00;
    else       r_sync <= {r_sync[0], i_d};
  end

  assign w_samp = r_sync[1];
`else
  assign w_samp = i_d;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_s <= 1'b0;
      r_d <= 1'b0;
    end else begin
      r_s <= w_samp;
      r_d <= r_s;
    end
  end

  assign o_s    = r_s;
  assign o_rise = r_s & ~r_d;
  assign o_fall = ~r_s & r_d;

endmodule

// File: rtl/clk_div_monitor.sv
// Measures period and high time of a divided clock and flags mismatch/timeout.
// Optional input synchroniser: define DIV_MON_SYNC_EN (see edge_det).
module clk_div_monitor
  import clk_div_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             div_in,
  input  logic [CNT_W-1:0] exp_period,
  input  logic [CNT_W-1:0] exp_high,
  input  logic             clr_err,
  output logic [CNT_W-1:0] meas_period,
  output logic [CNT_W-1:0] meas_high,
  output logic             meas_valid,
  output logic             mismatch,
  output logic             timeout,
  output div_mon_state_t   dbg_state
);

  localparam logic [CNT_W-1:0] CNT_MAX  = '1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_MAX - 1'b1;

  div_mon_state_t   r_state;
  logic [CNT_W-1:0] r_per_cnt;
  logic [CNT_W-1:0] r_hi_cnt;
  logic [CNT_W-1:0] r_hi_shadow;
  logic [CNT_W-1:0] r_meas_period;
  logic [CNT_W-1:0] r_meas_high;
  logic             r_meas_valid;
  logic             r_mismatch;
  logic             r_timeout;

  logic             w_s;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_period;
  logic             w_meas_evt;
  logic             w_mis_set;
  logic             w_to_set;

  edge_det u_edge_det (
    .clk    (clk),
    .rstn   (rstn),
    .i_d    (div_in),
    .o_s    (w_s),
    .o_rise (w_rise),
    .o_fall (w_fall)
  );

  // A rise in MEAS closes a period; reaching CNT_MAX without one aborts it.
  always_comb begin
    w_period   = r_per_cnt + 1'b1;
    w_meas_evt = en && (r_state == ST_MEAS) && w_rise;
    w_mis_set  = w_meas_evt &&
                 (((exp_period != '0) && (w_period != exp_period)) ||
                  ((exp_high != '0) && (r_hi_shadow != exp_high)));
    w_to_set   = en && (r_state == ST_MEAS) && !w_rise && (r_per_cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state       <= ST_IDLE;
      r_per_cnt     <= '0;
      r_hi_cnt      <= '0;
      r_hi_shadow   <= '0;
      r_meas_period <= '0;
      r_meas_high   <= '0;
      r_meas_valid  <= 1'b0;
      r_mismatch    <= 1'b0;
      r_timeout     <= 1'b0;
    end else begin
      r_meas_valid <= 1'b0;
      // Set wins over a simultaneous clear.
      r_mismatch   <= (r_mismatch & ~clr_err) | w_mis_set;
      r_timeout    <= (r_timeout & ~clr_err) | w_to_set;

      if (!en) begin
        r_state   <= ST_IDLE;
        r_per_cnt <= '0;
        r_hi_cnt  <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_per_cnt <= '0;
            r_hi_cnt  <= '0;
            r_state   <= ST_ARM;
          end
          ST_ARM: begin
            // The first rise only provides the reference edge.
            if (w_rise) begin
              r_state   <= ST_MEAS;
              r_per_cnt <= '0;
              r_hi_cnt  <= {{(CNT_W-1){1'b0}}, 1'b1};
            end
          end
          ST_MEAS: begin
            if (w_rise) begin
              r_meas_period <= w_period;
              r_meas_high   <= r_hi_shadow;
              r_meas_valid  <= 1'b1;
              r_per_cnt     <= '0;
              r_hi_cnt      <= {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
              if (w_to_set) begin
                r_per_cnt <= CNT_MAX;
                r_state   <= ST_ARM;
              end else begin
                r_per_cnt <= r_per_cnt + 1'b1;
              end
              if (w_s && (r_hi_cnt != CNT_MAX)) r_hi_cnt <= r_hi_cnt + 1'b1;
              if (w_fall) r_hi_shadow <= r_hi_cnt;
            end
          end
          default: r_state <= ST_IDLE;
        endcase
      end
    end
  end

  assign meas_period = r_meas_period;
  assign meas_high   = r_meas_high;
  assign meas_valid  = r_meas_valid;
  assign mismatch    = r_mismatch;
  assign timeout     = r_timeout;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_clk_div_monitor.sv
// Directed plus randomized bench for clk_div_monitor against a rise-time based reference model.
module tb_clk_div_monitor;
  import clk_div_pkg::*;

  localparam int CNT_W = 8;
  localparam int MAXP  = (1 << CNT_W) - 1;

  // clock / reset
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic             en = 1'b0;
  logic             div_in = 1'b0;
  logic [CNT_W-1:0] exp_period = '0;
  logic [CNT_W-1:0] exp_high = '0;
  logic             clr_err = 1'b0;
  logic [CNT_W-1:0] meas_period;
  logic [CNT_W-1:0] meas_high;
  logic             meas_valid;
  logic             mismatch;
  logic             timeout;
  div_mon_state_t   dbg_state;

  clk_div_monitor #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .en         (en),
    .div_in     (div_in),
    .exp_period (exp_period),
    .exp_high   (exp_high),
    .clr_err    (clr_err),
    .meas_period(meas_period),
    .meas_high  (meas_high),
    .meas_valid (meas_valid),
    .mismatch   (mismatch),
    .timeout    (timeout),
    .dbg_state  (dbg_state)
  );

  int checks = 0;
  int errors = 0;

  // reference model: input history plus the time of the last reference rise
  bit w [0:8191];
  int ec = 0;
  bit m_active = 0;
  bit m_have_ref = 0;
  int m_ref_n = 0;
  bit m_valid = 0;
  int m_per = 0;
  int m_hi = 0;
  bit m_mis = 0;
  bit m_to = 0;
  int ph = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, ec);
    end
  endtask

  function automatic int run_len(input int s);
    int k = 0;
    while (w[s + k] && (s + k) < ec) k++;
    return k;
  endfunction

  task automatic model_edge(input bit e_in, input bit clr);
    bit rise;
    bit mis_set = 0;
    bit to_set = 0;
    int n = ec - 1;
    rise = (ec >= 2) && w[ec-1] && !w[ec-2];
    m_valid = 0;
    if (!e_in) begin
      m_active = 0;
      m_have_ref = 0;
    end else if (!m_active) begin
      m_active = 1;
      m_have_ref = 0;
    end else if (rise) begin
      if (m_have_ref) begin
        m_per = n - m_ref_n;
        m_hi = run_len(m_ref_n);
        m_valid = 1;
        mis_set = ((exp_period != 0) && (m_per != int'(exp_period))) ||
                  ((exp_high != 0) && (m_hi != int'(exp_high)));
      end
      m_have_ref = 1;
      m_ref_n = n;
    end else if (m_have_ref && (n - m_ref_n) == MAXP) begin
      to_set = 1;
      m_have_ref = 0;
    end
    m_mis = (m_mis & !clr) | mis_set;
    m_to = (m_to & !clr) | to_set;
  endtask

  task automatic compare_all();
    div_mon_state_t exp_st;
    exp_st = !m_active ? ST_IDLE : (!m_have_ref ? ST_ARM : ST_MEAS);
    check("meas_valid", meas_valid, m_valid);
    check("meas_period", meas_period, m_per);
    check("meas_high", meas_high, m_hi);
    check("mismatch", mismatch, m_mis);
    check("timeout", timeout, m_to);
    check("state", dbg_state, exp_st);
  endtask

  // driver tasks
  task automatic step(input bit d, input bit e_in, input bit clr);
    div_in = d;
    en = e_in;
    clr_err = clr;
    @(posedge clk);
    ec++;
    w[ec] = d;
    model_edge(e_in, clr);
    #1;
    compare_all();
  endtask

  task automatic run(input int p, input int h, input int cycles, input bit e_in);
    for (int i = 0; i < cycles; i++) begin
      step(ph < h, e_in, 1'b0);
      ph = (ph + 1) % p;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int p, h, sel;
    #1;
    compare_all();
    check("reset_valid", meas_valid, 0);
    #2 rstn = 1'b1;
    @(negedge clk);
    #4;

    // div10, matching expectations
    exp_period = 8'd10; exp_high = 8'd5; ph = 0;
    run(10, 5, 60, 1'b1);

    // div2
    exp_period = 8'd2; exp_high = 8'd1; ph = 0;
    run(2, 1, 20, 1'b1);

    // div4 against exp_period=10, then clear and re-detect
    exp_period = 8'd10; exp_high = 8'd0; ph = 0;
    run(4, 2, 12, 1'b1);
    check("div4_mis_set", mismatch, 1);
    step(ph < 2, 1'b1, 1'b1);
    ph = (ph + 1) % 4;
    run(4, 2, 10, 1'b1);

    // hold low until timeout, then restart div10
    exp_period = 8'd10; exp_high = 8'd5;
    for (int i = 0; i < 270; i++) step(1'b0, 1'b1, 1'b0);
    check("timeout_set", timeout, 1);
    check("timeout_arm", dbg_state, ST_ARM);
    step(1'b0, 1'b1, 1'b1);
    ph = 0;
    run(10, 5, 40, 1'b1);

    // drop en mid-period and re-enable
    run(10, 5, 4, 1'b0);
    run(10, 5, 25, 1'b1);

    // randomized segments
    for (int s = 0; s < 8; s++) begin
      p = $urandom_range(2, 40);
      h = $urandom_range(1, p - 1);
      sel = $urandom_range(0, 2);
      exp_period = (sel == 0) ? 8'd0 : (sel == 1) ? 8'(p) : 8'($urandom_range(2, 40));
      sel = $urandom_range(0, 2);
      exp_high = (sel == 0) ? 8'd0 : (sel == 1) ? 8'(h) : 8'($urandom_range(1, 20));
      ph = 0;
      for (int i = 0; i < 3 * p + 12; i++) begin
        step(ph < h, ($urandom_range(0, 49) != 0), ($urandom_range(0, 15) == 0));
        ph = (ph + 1) % p;
      end
    end

    // reset pulse mid-measurement
    exp_period = 8'd10; exp_high = 8'd0; ph = 0;
    run(10, 5, 27, 1'b1);
    #1 rstn = 1'b0;
    #1;
    w[ec] = 0; w[ec-1] = 0;
    m_active = 0; m_have_ref = 0; m_valid = 0;
    m_per = 0; m_hi = 0; m_mis = 0; m_to = 0;
    compare_all();
    #1 rstn = 1'b1;
    ph = 0;
    run(10, 5, 30, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
